uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver matching the team's `uart_tx`. It sits on the FPGA's RXD pin and recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) at a fixed baud rate derived from the 50 MHz system clock. Each good byte is delivered to downstream logic, such as the sensor command parser, with a one-cycle valid strobe. Bad frames are flagged with a one-cycle framing-error strobe.

## Interface
- `CLKS_PER_BIT`, default 5208: system clocks per bit. This gives 9600 bps at 50 MHz. Legal range is ≥ 8.
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-low. All state is cleared immediately while it is 0.
- `rxd`, input, 1: serial line. The line idles high. The input is asynchronous to `clk`.
- `rx_data`, output, 8: last correctly received byte. It holds its value until the next good frame. Reset value is 8'h00.
- `rx_valid`, output, 1: one-cycle pulse when `rx_data` has just been updated. Reset value is 0.
- `rx_frame_err`, output, 1: one-cycle pulse when the stop bit was sampled low. Reset value is 0.
- `rx_busy`, output, 1: high whenever the FSM is not in IDLE. Reset value is 0.

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. A third flop holds the previous synchronized value for edge detection.
- `HALF` = `CLKS_PER_BIT`/2, using integer division. The bit counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..limit and then resets to 0.
- FSM states:
  - **IDLE**: on a synchronized falling edge (prev=1, cur=0), go to START and clear the counter.
  - **START**: when count == `HALF`-1, sample the line.
    - If high (false start or glitch), go to IDLE. No strobe is raised.
    - If low, go to DATA. Clear the counter and set `bit_idx`=0.
  - **DATA**: when count == `CLKS_PER_BIT`-1, sample the line and shift it in at the MSB (shift right). Then clear the counter and increment `bit_idx`. After `bit_idx` 7 is sampled, go to STOP. At that point the shift register holds the byte with the LSB received first, in bit 0.
  - **STOP**: when count == `CLKS_PER_BIT`-1, sample the line.
    - If 1, load `rx_data` from the shift register, pulse `rx_valid`, and go to IDLE.
    - If 0, pulse `rx_frame_err`, leave `rx_data` unchanged, and go to WAIT_IDLE.
  - **WAIT_IDLE**: stay here until the synchronized line is 1, then go to IDLE. This prevents a break condition from producing repeated frames.
- Back-to-back frames work: returning to IDLE at mid-stop-bit leaves half a bit period to detect the next start edge.
- `rx_valid` and `rx_frame_err` are never asserted in the same cycle.
- A reset asserted mid-frame aborts the frame. No strobe is raised, and `rx_data` returns to 8'h00.

## Timing
- From a pin falling edge to START entry: 3 clocks (2 synchronizer stages plus edge detect).
- The start sample is taken `HALF` clocks after START entry. Each subsequent sample is taken exactly `CLKS_PER_BIT` clocks after the previous one.
- `rx_valid` or `rx_frame_err` asserts `HALF` + 9·`CLKS_PER_BIT` clocks after START entry. Each strobe is high for exactly 1 cycle.
- `rx_data` changes in the same cycle that `rx_valid` rises, and it is stable afterwards.
- `rx_busy` rises the cycle after START entry is registered. It falls in the cycle the FSM returns to IDLE.
- Tolerated baud mismatch is ±2 % or better, limited by the mid-bit sampling.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:** each sample (start, data, and stop) is the 2-of-3 majority of the synchronized line at count = target-2, target-1, and target. Here target is the sample point defined in Operation. Any single-clock glitch near the sample point is rejected. Sample timing and strobe latency are unchanged.
- **Not defined:** a single synchronized sample is taken at the target count. No vote registers are built.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the default `CLKS_PER_BIT` constant 5208, which is shared with `uart_tx`;
  - `DATA_BITS` = 8.
- Sub-module `uart_sync2`: a 2-flop synchronizer with a reset value parameter. It is reusable for other async pins.

## Test plan
- **Byte 0x41:** drive 'A' at `BIT_PERIOD` 104160 ns → `rx_data`=8'h41, exactly one `rx_valid` pulse, `rx_frame_err` stays 0, and `rx_busy` low after the frame.
- **Byte 25 (8'h19) right after 0x41,** with the stop bit exactly 1 bit long → two `rx_valid` pulses, with `rx_data` equal to 8'h41 and then 8'h19. No frame is missed.
- **False start:** `rxd` low for 1000 clocks, then high → FSM returns to IDLE at `HALF`, no strobe, `rx_data` unchanged.
- **Framing error:** send 8'hA5 with the stop bit 0 and the line held low for 3 more bits → one `rx_frame_err` pulse, `rx_data` unchanged, and `rx_busy` high until `rxd` rises. A following frame of 8'h3C is received correctly.
- **Reset mid-frame:** assert `rst`=0 during data bit 4 → all outputs 0 immediately. After release, the next clean frame of 8'h7E is received.
- **Mid-bit glitch:** a 1-clock high pulse at the sample point of data bit 0 in 8'h00 → with the macro defined, `rx_data`=8'h00. Without the macro, `rx_data`=8'h01.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (state encoding, default bit timing, frame width).
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_e;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte bus from uart_rx (master) to downstream consumers (slave).
interface uart_rx_if;
    import uart_pkg::*;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_busy;
    modport master (output rx_data, rx_valid, rx_frame_err, rx_busy);
    modport slave  (input  rx_data, rx_valid, rx_frame_err, rx_busy);
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input pin, configurable reset value.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q, sync_d;
    assign sync_d = {sync_q[0], d};
    assign q = sync_q[1];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= {2{RST_VAL}};
        else      sync_q <= sync_d;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, valid and framing-error strobes.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three clocks.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rxd,
    uart_rx_if.master rx
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_T = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, err_q, err_d, prev_q, prev_d;
    logic                 rx_s, samp;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rx_s));

`ifdef UART_RX_MAJORITY_EN
    // hist_q holds the line at target-2 and target-1 when the target count is reached
    logic [1:0] hist_q, hist_d;
    assign hist_d = {hist_q[0], rx_s};
    assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hist_q <= 2'b11;
        else      hist_q <= hist_d;
    end
`else
    assign samp = rx_s;
`endif

    assign prev_d = rx_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) state_d = START;
            end
            START: if (cnt_q == HALF_T) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = samp ? IDLE : DATA;
            end
            DATA: if (cnt_q == FULL_T) begin
                cnt_d   = '0;
                shift_d = {samp, shift_q[DATA_BITS-1:1]};
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) state_d = STOP;
            end
            STOP: if (cnt_q == FULL_T) begin
                cnt_d   = '0;
                valid_d = samp;
                err_d   = !samp;
                data_d  = samp ? shift_q : data_q;
                state_d = samp ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            prev_q  <= prev_d;
        end
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_valid     = valid_q;
    assign rx.rx_frame_err = err_q;
    assign rx.rx_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx at 16 clocks per bit with hand-computed results.
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if rx_if ();
    uart_rx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .rxd(rxd), .rx(rx_if));

    int total = 0, bad = 0, cyc = 0, n_vld = 0, n_err = 0, vld_cyc = 0;
    logic [7:0] cap[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_if.rx_valid) begin
            n_vld++;
            vld_cyc = cyc;
            cap.push_back(rx_if.rx_data);
        end
        if (rx_if.rx_frame_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop;
        tick(CPB);
    endtask

    int t0, v, e, n;
    logic [7:0] glitch_exp;

    initial begin
        tick(3);
        check("rst_data", rx_if.rx_data, 8'h00);
        check("rst_valid", rx_if.rx_valid, 1'b0);
        check("rst_err", rx_if.rx_frame_err, 1'b0);
        check("rst_busy", rx_if.rx_busy, 1'b0);
        rst = 1'b1;
        tick(5);

        t0 = cyc;
        send(8'h41, 1'b1);
        tick(4);
        check("a_data", rx_if.rx_data, 8'h41);
        check("a_nvld", n_vld, 1);
        check("a_nerr", n_err, 0);
        check("a_busy", rx_if.rx_busy, 1'b0);
        check("a_latency", vld_cyc - t0, LAT);

        n = cap.size();
        send(8'h41, 1'b1);
        send(8'h19, 1'b1);
        tick(4);
        check("b2b_nvld", n_vld, 3);
        check("b2b_first", cap[n], 8'h41);
        check("b2b_second", cap[n+1], 8'h19);
        check("b2b_data", rx_if.rx_data, 8'h19);

        v = n_vld;
        e = n_err;
        rxd = 1'b0;
        tick(4);
        check("fs_busy_hi", rx_if.rx_busy, 1'b1);
        rxd = 1'b1;
        tick(20);
        check("fs_busy_lo", rx_if.rx_busy, 1'b0);
        check("fs_nvld", n_vld, v);
        check("fs_nerr", n_err, e);
        check("fs_data", rx_if.rx_data, 8'h19);

        send(8'hA5, 1'b0);
        tick(3 * CPB);
        check("fe_nerr", n_err, e + 1);
        check("fe_nvld", n_vld, v);
        check("fe_data", rx_if.rx_data, 8'h19);
        check("fe_busy_hi", rx_if.rx_busy, 1'b1);
        rxd = 1'b1;
        tick(4);
        check("fe_busy_lo", rx_if.rx_busy, 1'b0);
        send(8'h3C, 1'b1);
        tick(4);
        check("fe_next_data", rx_if.rx_data, 8'h3C);
        check("fe_next_nvld", n_vld, v + 1);

        v = n_vld;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = ((8'h7E >> i) & 8'h01) != 0;
            tick(CPB);
        end
        rxd = 1'b1;
        tick(HALF);
        rst = 1'b0;
        #1;
        check("mr_data", rx_if.rx_data, 8'h00);
        check("mr_valid", rx_if.rx_valid, 1'b0);
        check("mr_err", rx_if.rx_frame_err, 1'b0);
        check("mr_busy", rx_if.rx_busy, 1'b0);
        tick(2);
        rst = 1'b1;
        tick(5);
        send(8'h7E, 1'b1);
        tick(4);
        check("mr_next_data", rx_if.rx_data, 8'h7E);
        check("mr_next_nvld", n_vld, v + 1);

`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h01;
`endif
        v = n_vld;
        rxd = 1'b0;
        tick(CPB + HALF);
        rxd = 1'b1;
        tick(1);
        rxd = 1'b0;
        tick(9 * CPB - CPB - HALF - 1);
        rxd = 1'b1;
        tick(CPB + 4);
        check("gl_data", rx_if.rx_data, glitch_exp);
        check("gl_nvld", n_vld, v + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
